// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register and ready-handshake instruction fetch; IFETCH_PERF_CNT_EN adds retired/stall counters.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       Instruction,
    output logic [31:0]       PC,
    output logic [31:0]       opcplus4,
    output logic              inst_valid,
    input  logic              advance,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Zero,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic [31:0]       Addr_result,
    input  logic [31:0]       read_data_1
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt
`endif
);
    typedef enum logic {FETCH, HOLD} state_t;
    state_t      state, state_next;
    logic [31:0] next_pc;
    logic        unused_bits;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH;
            PC          <= RESET_PC;
            Instruction <= 32'h0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ready) Instruction <= imem_rdata;
            if (state == HOLD && advance) PC <= next_pc;
        end
    end

    always_comb begin
        state_next = (state == FETCH) ? (imem_ready ? HOLD : FETCH) : (advance ? FETCH : HOLD);
        next_pc    = Jr ? {read_data_1[31:2], 2'b00} :
                     (Jmp || Jal) ? {opcplus4[31:28], Instruction[25:0], 2'b00} :
                     ((Branch && Zero) || (nBranch && !Zero)) ? {Addr_result[31:2], 2'b00} :
                     opcplus4;
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = PC[ADDR_W+1:2];
    assign opcplus4    = PC + 32'd4;
    assign inst_valid  = (state == HOLD);
    // Targets are word-aligned, so the low address bits are intentionally dropped.
    assign unused_bits = ^{read_data_1[1:0], Addr_result[1:0]};

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_cnt <= 32'h0;
            stall_cnt   <= 32'h0;
        end else begin
            if (state == HOLD && advance) retired_cnt <= retired_cnt + 32'd1;
            if (state == FETCH && !imem_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;
    logic        clock = 1'b0;
    logic        reset, imem_req, imem_ready, inst_valid, advance;
    logic        Branch, nBranch, Zero, Jmp, Jal, Jr;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata, Instruction, PC, opcplus4, Addr_result, read_data_1;
    int          checks = 0;
    int          failures = 0;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt, r0, s0;
`endif

    ifetch_unit #(.RESET_PC(32'h0), .ADDR_W(14)) dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Instruction(Instruction),
        .PC(PC), .opcplus4(opcplus4), .inst_valid(inst_valid), .advance(advance),
        .Branch(Branch), .nBranch(nBranch), .Zero(Zero), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
        .Addr_result(Addr_result), .read_data_1(read_data_1)
`ifdef IFETCH_PERF_CNT_EN
        , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input int waits, input logic [31:0] data);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            @(negedge clock);
        end
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        imem_rdata = data;
        @(negedge clock);
        imem_ready = 1'b0;
        chk("fetch_valid", {31'b0, inst_valid}, 32'd1);
        chk("fetch_instr", Instruction, data);
    endtask

    task automatic commit();
        advance = 1'b1;
        @(negedge clock);
        {advance, Branch, nBranch, Zero, Jmp, Jal, Jr} = '0;
        Addr_result = 32'h0;
        read_data_1 = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        {imem_ready, advance, Branch, nBranch, Zero, Jmp, Jal, Jr} = '0;
        imem_rdata = 32'h0; Addr_result = 32'h0; read_data_1 = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_req", {31'b0, imem_req}, 32'd1);
        chk("rst_addr", {18'b0, imem_addr}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_pc4", opcplus4, 32'h4);
        chk("rst_instr", Instruction, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_retired", retired_cnt, 32'h0);
        chk("rst_stall", stall_cnt, 32'h0);
`endif
        fetch(0, 32'h2001_0005);
        chk("f0_pc", PC, 32'h0);
        chk("f0_pc4", opcplus4, 32'h4);
        chk("hold_req", {31'b0, imem_req}, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_ready = 1'b0;
        chk("hold_ignore_rdy", Instruction, 32'h2001_0005);
        chk("hold_still_valid", {31'b0, inst_valid}, 32'd1);
        commit();
        chk("seq_pc4", PC, 32'h4);
        chk("seq_addr1", {18'b0, imem_addr}, 32'd1);
        chk("seq_invalid", {31'b0, inst_valid}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        r0 = retired_cnt;
        s0 = stall_cnt;
`endif
        fetch(2, 32'h0000_0000);
`ifdef IFETCH_PERF_CNT_EN
        chk("stall_plus2", stall_cnt - s0, 32'd2);
`endif
        commit();
`ifdef IFETCH_PERF_CNT_EN
        chk("retired_plus1", retired_cnt - r0, 32'd1);
`endif
        chk("seq_pc8", PC, 32'h8);
        chk("seq_addr2", {18'b0, imem_addr}, 32'd2);
        fetch(0, 32'h1000_0003);
        Branch = 1'b1; Zero = 1'b1; Addr_result = 32'h40;
        commit();
        chk("beq_taken", PC, 32'h40);
        chk("beq_addr", {18'b0, imem_addr}, 32'd16);
        fetch(0, 32'h1000_0003);
        Branch = 1'b1; Zero = 1'b0; Addr_result = 32'h80;
        commit();
        chk("beq_not_taken", PC, 32'h44);
        fetch(0, 32'h1400_0003);
        nBranch = 1'b1; Zero = 1'b0; Addr_result = 32'h43;
        commit();
        chk("bne_taken", PC, 32'h40);
        fetch(0, 32'h0000_0008);
        Jr = 1'b1; read_data_1 = 32'h1000_0010;
        commit();
        chk("jr_pc", PC, 32'h1000_0010);
        fetch(0, 32'h0C00_0020);
        chk("jal_pc4", opcplus4, 32'h1000_0014);
        Jal = 1'b1;
        commit();
        chk("jal_target", PC, 32'h1000_0080);
        fetch(0, 32'h0800_0100);
        Jr = 1'b1; Jmp = 1'b1; read_data_1 = 32'h0000_0123;
        commit();
        chk("jr_wins", PC, 32'h0000_0120);
        fetch(0, 32'h0800_0100);
        Jmp = 1'b1;
        commit();
        chk("jmp_target", PC, 32'h0000_0400);
        fetch(0, 32'h0000_0008);
        Jr = 1'b1; read_data_1 = 32'hFFFF_FFFF;
        commit();
        chk("top_pc", PC, 32'hFFFF_FFFC);
        chk("wrap_pc4", opcplus4, 32'h0);
        fetch(0, 32'h0);
        commit();
        chk("wrap_pc", PC, 32'h0);
        imem_ready = 1'b0;
        repeat (5) @(negedge clock);
        chk("stall_req", {31'b0, imem_req}, 32'd1);
        chk("stall_addr", {18'b0, imem_addr}, 32'd0);
        chk("stall_valid", {31'b0, inst_valid}, 32'd0);
        fetch(0, 32'h0000_0008);
        Jr = 1'b1; read_data_1 = 32'h0000_0200;
        commit();
        fetch(0, 32'h1234_5678);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_hold_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_hold_pc", PC, 32'h0);
        chk("rst_hold_instr", Instruction, 32'h0);
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        @(negedge clock);
        reset = 1'b0; imem_ready = 1'b0;
        chk("rst_fetch_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_fetch_instr", Instruction, 32'h0);
        chk("rst_fetch_req", {31'b0, imem_req}, 32'd1);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst2_retired", retired_cnt, 32'h0);
        chk("rst2_stall", stall_cnt, 32'h0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
